nibble_packer: RTL and testbench
================================

# nibble_packer

Downstream consumer of the 4-bit code stream `c` produced by the `text` block. It packs successive nibbles into a W-bit word, first nibble in the least-significant position, and presents each word on a valid/ready output port. Two sources of backpressure are supported: a single-entry output register, and a hold state that stalls the nibble input while a completed word waits for that register. A flush input emits a partially filled, zero-padded word.

## Interface
Parameters:
- `NIBBLES`, default 8, is the number of nibbles per word. Legal range is 2..15. Word width is W = 4*NIBBLES.

Ports (name, direction, width, meaning):
- `clk`, in, 1: rising-edge clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `c`, in, 4: nibble data from upstream.
- `c_valid`, in, 1: `c` is valid this cycle.
- `c_ready`, out, 1: the packer accepts `c` this cycle.
- `flush`, in, 1: request to emit the current partial word.
- `word`, out, W: packed word.
- `word_len`, out, 4: number of valid nibbles in `word` (1..NIBBLES).
- `word_valid`, out, 1: `word` and `word_len` are valid.
- `word_ready`, in, 1: downstream takes `word` this cycle.

## Operation
- State:
  - `acc` (W bits): accumulator.
  - `idx` (0..NIBBLES): count of nibbles in `acc`.
  - `fsm`: either FILL or HOLD.
  - Output register: `word`, `word_len`, `word_valid`.
- Definitions used below:
  - accept = `c_valid & c_ready`.
  - slot_free = `!word_valid | word_ready`.
- `c_ready` = (`fsm` == FILL). It is combinational from state only.
- FILL:
  - On accept, `acc[4*idx +: 4]` <= `c` and `idx` increments.
  - Let n = idx + accept, the nibble count after this edge.
  - Emit when n == NIBBLES, or when `flush` & n > 0.
  - On emit with slot_free: the output register loads `acc` (with the new nibble merged in, unused upper nibbles forced to 0). `word_len` <= n and `word_valid` <= 1. `acc` and `idx` clear, and `fsm` stays FILL.
  - On emit without slot_free: `acc` and `idx` keep the merged content and `fsm` <= HOLD.
  - `flush` with n == 0 is a no-op.
- HOLD:
  - `c_ready` = 0 and `flush` is ignored.
  - On an edge with `word_ready` = 1 (so the slot frees), the output loads `acc` and `idx`, `acc`/`idx` clear, and `fsm` <= FILL.
- Output register:
  - On `word_valid & word_ready` with no new load, `word_valid` <= 0.
  - `word` and `word_len` are held until the next load. They are not cleared on handshake.
- Arithmetic: `idx` never exceeds NIBBLES, and there is no wrap-around. Padding nibbles are always 0.

## Timing
- Reset (`rst_n` low, asynchronous) forces:
  - `acc` = 0, `idx` = 0, `fsm` = FILL.
  - `word` = 0, `word_len` = 0, `word_valid` = 0.
  - `c_ready` = 1.
- Reset mid-operation discards any partial word and any un-taken output without emitting them.
- Latency: the word appears with `word_valid` = 1 in the cycle after the edge that accepts its last nibble (or executes the flush), provided slot_free held at that edge.
- Throughput: one nibble per cycle, with no bubble at word boundaries while `word_ready` = 1.
- Full word plus busy slot: `c_ready` drops in the cycle after the completing nibble is accepted. It rises in the cycle after the edge where `word_ready` = 1.
- Simultaneous nibble and `flush` in FILL: the nibble is included in the flushed word.
- `word` is stable while `word_valid` = 1 and `word_ready` = 0.

## Test plan
All scenarios use NIBBLES = 8.
- Feed nibbles 1..8 back-to-back with `word_ready` = 1. Required: `word` = 32'h87654321, `word_len` = 8, and `word_valid` high for exactly one cycle, in the cycle after the 8th accept.
- Stream 16 nibbles 0..F with `word_ready` = 1. Required: words 32'h76543210 then 32'hFEDCBA98, and `c_ready` never drops.
- Same stream with `word_ready` = 0. Required:
  - First word is held stable.
  - `c_ready` goes to 0 after the 16th accept.
  - Raising `word_ready` for one cycle loads 32'hFEDCBA98 on the next edge, and `c_ready` returns to 1.
- Flush tests. Send A, B, C, then pulse `flush` alone. Required: `word` = 32'h00000CBA, `word_len` = 3. Then:
  - Pulsing `flush` with `idx` = 0 produces no `word_valid`.
  - `flush` in the same cycle as the 3rd nibble also yields `word_len` = 3.
- Accept 5 nibbles with an un-taken word pending, then pull `rst_n` low mid-cycle. Required: `word_valid` = 0 and `word` = 0 immediately. After release, nibbles 1..8 produce a clean 32'h87654321.

Source files
------------

// File: rtl/nibble_packer.sv
// nibble_packer: packs a 4-bit code stream into W-bit words, first nibble in
// the least-significant slot, with a one-entry output register and a HOLD
// state that stalls input while a completed word waits for that register.
module nibble_packer #(
   parameter int NIBBLES = 8,
   parameter int W       = 4 * NIBBLES
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [3:0]   c,
   input  logic         c_valid,
   output logic         c_ready,
   input  logic         flush,
   output logic [W-1:0] word,
   output logic [3:0]   word_len,
   output logic         word_valid,
   input  logic         word_ready
);

   typedef enum logic {FILL, HOLD} state_t;

   state_t         fsm, fsm_nxt;
   logic [W-1:0]   acc, acc_nxt, acc_m;
   logic [3:0]     idx, idx_nxt;
   logic [4:0]     n;
   logic [W-1:0]   word_nxt;
   logic [3:0]     len_nxt;
   logic           vld_nxt;
   logic           accept, slot_free, emit;

   assign c_ready   = (fsm == FILL);
   assign accept    = c_valid & c_ready;
   assign slot_free = !word_valid | word_ready;
   // Slots above idx are always zero, so OR-ing the new nibble in merges it
   // and leaves the padding clean.
   assign acc_m     = accept ? (acc | ({{(W-4){1'b0}}, c} << {idx, 2'b00})) : acc;
   assign n         = {1'b0, idx} + {4'd0, accept};
   assign emit      = (fsm == FILL) &&
                      ((n == 5'(NIBBLES)) || (flush && (n != 5'd0)));

   // Next-state and output-register load decisions.
   always_comb begin
      fsm_nxt  = fsm;
      acc_nxt  = acc;
      idx_nxt  = idx;
      word_nxt = word;
      len_nxt  = word_len;
      vld_nxt  = word_valid;
      // A handshake with no new load empties the output slot.
      if (word_valid && word_ready) vld_nxt = 1'b0;
      case (fsm)
         FILL: begin
            acc_nxt = acc_m;
            idx_nxt = n[3:0];
            if (emit) begin
               if (slot_free) begin
                  word_nxt = acc_m;
                  len_nxt  = n[3:0];
                  vld_nxt  = 1'b1;
                  acc_nxt  = '0;
                  idx_nxt  = '0;
               end else begin
                  fsm_nxt  = HOLD;
               end
            end
         end
         HOLD: begin
            // Input stalled and flush ignored until the slot frees.
            if (word_ready) begin
               word_nxt = acc;
               len_nxt  = idx;
               vld_nxt  = 1'b1;
               acc_nxt  = '0;
               idx_nxt  = '0;
               fsm_nxt  = FILL;
            end
         end
         default: fsm_nxt = FILL;
      endcase
   end

   // State, accumulator and output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm        <= FILL;
         acc        <= '0;
         idx        <= '0;
         word       <= '0;
         word_len   <= '0;
         word_valid <= 1'b0;
      end else begin
         fsm        <= fsm_nxt;
         acc        <= acc_nxt;
         idx        <= idx_nxt;
         word       <= word_nxt;
         word_len   <= len_nxt;
         word_valid <= vld_nxt;
      end
   end

endmodule

// File: tb/tb_nibble_packer.sv
// tb_nibble_packer: directed test-plan scenarios plus random traffic, each
// cycle compared against a queue-based reference model of the packer.
module tb_nibble_packer;

   localparam int NIB = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  c = '0;
   logic        c_valid = 1'b0;
   logic        c_ready;
   logic        flush = 1'b0;
   logic [31:0] word;
   logic [3:0]  word_len;
   logic        word_valid;
   logic        word_ready = 1'b0;

   int checks = 0;
   int passed = 0;

   // Reference model: pending nibbles, a parked completed word, output slot.
   logic [3:0]  q[$];
   bit          pend_v;
   logic [31:0] pend_w;
   logic [3:0]  pend_l;
   logic [31:0] m_word;
   logic [3:0]  m_len;
   bit          m_valid;

   nibble_packer #(.NIBBLES(NIB)) dut (
      .clk(clk), .rst_n(rst_n), .c(c), .c_valid(c_valid), .c_ready(c_ready),
      .flush(flush), .word(word), .word_len(word_len),
      .word_valid(word_valid), .word_ready(word_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs === exp) passed++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
   endtask

   function automatic logic [31:0] pack();
      logic [31:0] r = '0;
      foreach (q[i]) r = r | (32'(q[i]) << (4 * i));
      return r;
   endfunction

   task automatic model_reset();
      q.delete();
      pend_v = 0; pend_w = '0; pend_l = '0;
      m_word = '0; m_len = '0; m_valid = 0;
   endtask

   // Advance the model across one clock edge using the current inputs.
   task automatic model_edge();
      bit free;
      free = !m_valid || word_ready;
      if (pend_v) begin
         if (word_ready) begin
            m_word = pend_w; m_len = pend_l; m_valid = 1; pend_v = 0;
         end
      end else begin
         if (c_valid) q.push_back(c);
         if (q.size() == NIB || (flush && q.size() > 0)) begin
            if (free) begin
               m_word = pack(); m_len = 4'(q.size()); m_valid = 1;
            end else begin
               pend_w = pack(); pend_l = 4'(q.size()); pend_v = 1;
            end
            q.delete();
         end else if (m_valid && word_ready) begin
            m_valid = 0;
         end
      end
   endtask

   // Drive one cycle: compare outputs against the model, then take the edge.
   task automatic cyc(input bit cv, input logic [3:0] cd, input bit fl, input bit wr);
      c_valid = cv; c = cd; flush = fl; word_ready = wr;
      #1;
      chk("c_ready", 64'(c_ready), 64'(!pend_v));
      chk("word_valid", 64'(word_valid), 64'(m_valid));
      chk("word", 64'(word), 64'(m_word));
      chk("word_len", 64'(word_len), 64'(m_len));
      model_edge();
      @(posedge clk); #1;
   endtask

   initial begin
      model_reset();
      #12;
      chk("rst_word", 64'(word), 64'h0);
      chk("rst_valid", 64'(word_valid), 64'h0);
      chk("rst_ready", 64'(c_ready), 64'h1);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Nibbles 1..8 back-to-back, downstream always ready.
      for (int i = 1; i <= 8; i++) cyc(1, 4'(i), 0, 1);
      chk("w1_word", 64'(word), 64'h87654321);
      chk("w1_len", 64'(word_len), 64'd8);
      chk("w1_valid", 64'(word_valid), 64'h1);
      cyc(0, 0, 0, 1);
      chk("w1_pulse", 64'(word_valid), 64'h0);

      // 0..F streamed with ready high: two words, no stall.
      for (int i = 0; i < 16; i++) begin
         cyc(1, 4'(i), 0, 1);
         if (i == 7) chk("s1_word", 64'(word), 64'h76543210);
      end
      chk("s2_word", 64'(word), 64'hFEDCBA98);
      cyc(0, 0, 0, 1);

      // Same stream with ready low: first word held, second parks in HOLD.
      for (int i = 0; i < 16; i++) cyc(1, 4'(i), 0, 0);
      cyc(1, 4'h5, 0, 0);
      chk("hold_ready", 64'(c_ready), 64'h0);
      chk("hold_word", 64'(word), 64'h76543210);
      cyc(0, 0, 0, 1);
      chk("rel_word", 64'(word), 64'hFEDCBA98);
      chk("rel_ready", 64'(c_ready), 64'h1);
      cyc(0, 0, 0, 1);

      // Flush: partial word, empty flush, nibble-plus-flush.
      cyc(1, 4'hA, 0, 1); cyc(1, 4'hB, 0, 1); cyc(1, 4'hC, 0, 1);
      cyc(0, 0, 1, 1);
      chk("fl_word", 64'(word), 64'h00000CBA);
      chk("fl_len", 64'(word_len), 64'd3);
      cyc(0, 0, 1, 1);
      chk("fl_empty", 64'(word_valid), 64'h0);
      cyc(1, 4'h1, 0, 1); cyc(1, 4'h2, 0, 1); cyc(1, 4'h3, 1, 1);
      chk("fl3_len", 64'(word_len), 64'd3);
      chk("fl3_word", 64'(word), 64'h00000321);
      cyc(0, 0, 0, 1);

      // Pending un-taken word plus 5 nibbles, then asynchronous reset.
      for (int i = 0; i < 13; i++) cyc(1, 4'(i + 3), 0, 0);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_valid", 64'(word_valid), 64'h0);
      chk("arst_word", 64'(word), 64'h0);
      chk("arst_ready", 64'(c_ready), 64'h1);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 1; i <= 8; i++) cyc(1, 4'(i), 0, 1);
      chk("post_word", 64'(word), 64'h87654321);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++)
         cyc(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 2) != 0));
      cyc(0, 0, 0, 1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

endmodule
